if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// Fetch-to-decode skid FIFO: buffers fetch bundles, presents the head entry
// first-word-fall-through, and stalls fetch when full or after a halt is taken.
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in_id,
  input  logic [31:0]              pc_in_id,
  input  logic [31:0]              pc4_in_id,
  input  logic [31:0]              instr_in_id,
  input  logic                     halt_in_id,
  input  logic                     flush_in_id,
  input  logic                     ready_in_id,
  output logic                     valid_out_id,
  output logic [31:0]              pc_out_id,
  output logic [31:0]              pc4_out_id,
  output logic [31:0]              instr_out_id,
  output logic                     halt_out_id,
  output logic                     stall_out_id,
  output logic [$clog2(DEPTH):0]   count_out_id
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          halted;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          halt_mem  [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Stall depends only on registered state, so a same-cycle pop cannot
  // release fetch; fetch simply re-presents its bundle next cycle.
  assign stall_out_id = full | halted;

  assign push = valid_in_id & ~stall_out_id & ~flush_in_id;
  assign pop  = ~empty & ready_in_id & ~flush_in_id;

  always_ff @(posedge clk) begin
    if (rst || flush_in_id) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      halted <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && halt_in_id) halted <= 1'b1;
    end
  end

  // Storage is never visible while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[tail]    <= pc_in_id;
      pc4_mem[tail]   <= pc4_in_id;
      instr_mem[tail] <= instr_in_id;
      halt_mem[tail]  <= halt_in_id;
    end
  end

  always_comb begin
    valid_out_id = 1'b0;
    pc_out_id    = 32'h0;
    pc4_out_id   = 32'h0;
    instr_out_id = NOP_INSTR;
    halt_out_id  = 1'b0;
    if (!empty) begin
      valid_out_id = 1'b1;
      pc_out_id    = pc_mem[head];
      pc4_out_id   = pc4_mem[head];
      instr_out_id = instr_mem[head];
      halt_out_id  = halt_mem[head];
    end
  end

  assign count_out_id = count;

endmodule
